// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: shared CPU types for the write-back stage and register bank write port
package writeback_unit_pkg;
    localparam int REG_ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'h0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_count_e;

    // A register is pending if a buffered load or the write currently on the port targets it.
    function automatic logic dest_pending(
        input logic [REG_ADDR_W-1:0]      r,
        input logic [1:0]                 ent_valid,
        input logic [1:0][REG_ADDR_W-1:0] ent_dest,
        input logic                       we,
        input logic [REG_ADDR_W-1:0]      wr
    );
        return r != REG_ZERO && ((ent_valid[0] && ent_dest[0] == r) ||
                                 (ent_valid[1] && ent_dest[1] == r) ||
                                 (we && wr == r));
    endfunction
endpackage

// File: rtl/writeback_unit_if.sv
// writeback_unit_if: ALU/load result streams, hazard check, stall and register bank write port
// master: upstream pipeline + register bank side; slave: writeback_unit
interface writeback_unit_if;
    import writeback_unit_pkg::*;
    logic                  i_alu_valid;
    logic [REG_ADDR_W-1:0] i_alu_dest;
    logic [DATA_W-1:0]     i_alu_data;
    logic                  i_ld_valid;
    logic [REG_ADDR_W-1:0] i_ld_dest;
    logic [DATA_W-1:0]     i_ld_data;
    logic                  o_ld_ready;
    logic [REG_ADDR_W-1:0] i_chk_reg1;
    logic [REG_ADDR_W-1:0] i_chk_reg2;
    logic                  o_pending1;
    logic                  o_pending2;
    logic                  o_alu_stall;
    logic                  o_write_en;
    logic [REG_ADDR_W-1:0] o_write_reg;
    logic [DATA_W-1:0]     o_write_data;

    modport master (
        output i_alu_valid, i_alu_dest, i_alu_data, i_ld_valid, i_ld_dest, i_ld_data,
               i_chk_reg1, i_chk_reg2,
        input  o_ld_ready, o_pending1, o_pending2, o_alu_stall, o_write_en, o_write_reg, o_write_data
    );

    modport slave (
        input  i_alu_valid, i_alu_dest, i_alu_data, i_ld_valid, i_ld_dest, i_ld_data,
               i_chk_reg1, i_chk_reg2,
        output o_ld_ready, o_pending1, o_pending2, o_alu_stall, o_write_en, o_write_reg, o_write_data
    );
endinterface

// File: rtl/writeback_unit_fifo2.sv
// writeback_unit_fifo2: 2-entry ordered load buffer with per-entry dest taps for hazard compare
// i_enq/i_enq_entry push at tail, i_deq pops head; o_head, o_count, o_entry_valid/o_entry_dest
// Caller guarantees no enqueue when FULL and no dequeue when EMPTY.
module writeback_unit_fifo2
    import writeback_unit_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_enq,
    input  wb_entry_t                   i_enq_entry,
    input  logic                        i_deq,
    output wb_entry_t                   o_head,
    output fifo_count_e                 o_count,
    output logic [1:0]                  o_entry_valid,
    output logic [1:0][REG_ADDR_W-1:0]  o_entry_dest
);
    wb_entry_t   mem [2];
    logic        head_ptr, tail_ptr;
    fifo_count_e count, count_next;

    always_comb begin
        count_next = (i_enq == i_deq) ? count
                   : i_enq ? (count == EMPTY ? ONE : FULL)
                   : (count == FULL ? ONE : EMPTY);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count    <= EMPTY;
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
        end else begin
            count <= count_next;
            if (i_enq) tail_ptr <= ~tail_ptr;
            if (i_deq) head_ptr <= ~head_ptr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_enq) mem[tail_ptr] <= i_enq_entry;
    end

    assign o_head           = mem[head_ptr];
    assign o_count          = count;
    assign o_entry_valid[0] = count == FULL || (count == ONE && !head_ptr);
    assign o_entry_valid[1] = count == FULL || (count == ONE && head_ptr);
    assign o_entry_dest[0]  = mem[0].dest;
    assign o_entry_dest[1]  = mem[1].dest;
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU and load results into one ordered register bank write per cycle
// i_clk/i_reset plain; bus carries ALU/load inputs, o_ld_ready, hazard checks, o_alu_stall and write port
// Port priority: ALU, then buffered load, then bypassed incoming load.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)(
    input logic            i_clk,
    input logic            i_reset,
    writeback_unit_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    wb_entry_t                  head, sel, wr_q;
    fifo_count_e                count;
    logic [1:0]                 ent_valid;
    logic [1:0][REG_ADDR_W-1:0] ent_dest;
    logic                       ld_ready, alu_win, ld_live, buf_ne, deq, bypass, enq, sel_valid;
    logic                       we_q, stall_q;
    logic [3:0]                 starve, starve_next;

    assign ld_ready  = count != FULL;
    assign buf_ne    = count != EMPTY;
    assign alu_win   = bus.i_alu_valid && bus.i_alu_dest != REG_ZERO;
    // Dest-0 loads are accepted (handshake completes) but never reach the port or buffer.
    assign ld_live   = bus.i_ld_valid && ld_ready && bus.i_ld_dest != REG_ZERO;
    assign deq       = !alu_win && buf_ne;
    assign bypass    = !alu_win && !buf_ne && ld_live;
    assign enq       = ld_live && !bypass;
    assign sel_valid = alu_win || buf_ne || ld_live;
    assign sel       = alu_win ? wb_entry_t'{dest: bus.i_alu_dest, data: bus.i_alu_data}
                     : buf_ne  ? head
                     : wb_entry_t'{dest: bus.i_ld_dest, data: bus.i_ld_data};

    // A non-empty buffer that does not dequeue means the ALU took the port; clearing at the
    // limit lets the stall pulse last exactly one cycle.
    assign starve_next = (deq || !buf_ne || starve == LIMIT) ? 4'd0 : starve + 4'd1;

    writeback_unit_fifo2 u_fifo (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_enq         (enq),
        .i_enq_entry   (wb_entry_t'{dest: bus.i_ld_dest, data: bus.i_ld_data}),
        .i_deq         (deq),
        .o_head        (head),
        .o_count       (count),
        .o_entry_valid (ent_valid),
        .o_entry_dest  (ent_dest)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            we_q    <= 1'b0;
            wr_q    <= '0;
            stall_q <= 1'b0;
            starve  <= 4'd0;
        end else begin
            we_q    <= sel_valid;
            if (sel_valid) wr_q <= sel;
            stall_q <= starve_next == LIMIT;
            starve  <= starve_next;
        end
    end

    // Upstream must idle the ALU for one cycle after a stall request.
    assert property (@(posedge i_clk) disable iff (i_reset) stall_q |=> !bus.i_alu_valid);

    assign bus.o_ld_ready   = ld_ready;
    assign bus.o_alu_stall  = stall_q;
    assign bus.o_write_en   = we_q;
    assign bus.o_write_reg  = wr_q.dest;
    assign bus.o_write_data = wr_q.data;
    assign bus.o_pending1   = dest_pending(bus.i_chk_reg1, ent_valid, ent_dest, we_q, wr_q.dest);
    assign bus.o_pending2   = dest_pending(bus.i_chk_reg2, ent_valid, ent_dest, we_q, wr_q.dest);
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed and randomized checks of writeback_unit against a queue-based model
module tb_writeback_unit;
    import writeback_unit_pkg::*;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    writeback_unit_if bus();
    writeback_unit #(.STARVE_LIMIT(LIMIT)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: loads waiting for the port, starvation count, registered write port.
    wb_entry_t   q [$];
    int          starve = 0;
    logic        m_we = 1'b0, m_stall = 1'b0;
    logic [3:0]  m_wr = '0;
    logic [7:0]  m_wd = '0;
    logic        e_ready, e_p1, e_p2;

    function automatic logic pend(input logic [3:0] c);
        if (c == 4'd0) return 1'b0;
        if (m_we && m_wr == c) return 1'b1;
        foreach (q[i]) if (q[i].dest == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic av, input logic [3:0] ad, input logic [7:0] ax,
                         input logic lv, input logic [3:0] ld, input logic [7:0] lx,
                         input logic [3:0] c1, input logic [3:0] c2);
        bus.i_alu_valid = av; bus.i_alu_dest = ad; bus.i_alu_data = ax;
        bus.i_ld_valid  = lv; bus.i_ld_dest  = ld; bus.i_ld_data  = lx;
        bus.i_chk_reg1  = c1; bus.i_chk_reg2 = c2;
        @(negedge clk);
        e_ready = q.size() < 2;
        e_p1    = pend(c1);
        e_p2    = pend(c2);
    endtask

    task automatic advance();
        logic alu_w, ldw, was_ne, popped, byp;
        wb_entry_t e;
        if (rst) begin
            q.delete(); starve = 0; m_we = 0; m_wr = '0; m_wd = '0; m_stall = 0;
        end else begin
            was_ne = q.size() > 0;
            alu_w  = bus.i_alu_valid && bus.i_alu_dest != 0;
            ldw    = bus.i_ld_valid && q.size() < 2 && bus.i_ld_dest != 0;
            popped = 0;
            byp    = 0;
            if (alu_w) begin
                m_we = 1; m_wr = bus.i_alu_dest; m_wd = bus.i_alu_data;
            end else if (was_ne) begin
                e = q.pop_front(); m_we = 1; m_wr = e.dest; m_wd = e.data; popped = 1;
            end else if (ldw) begin
                m_we = 1; m_wr = bus.i_ld_dest; m_wd = bus.i_ld_data; byp = 1;
            end else m_we = 0;
            if (ldw && !byp) q.push_back('{dest: bus.i_ld_dest, data: bus.i_ld_data});
            starve  = (popped || !was_ne || starve == LIMIT) ? 0 : starve + 1;
            m_stall = starve == LIMIT;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0); advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0); advance();
        rst = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.o_write_en !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus.o_write_en); end
        checks++; if (bus.o_write_reg !== 4'h0) begin errors++; $display("FAIL reset_wr got %h want 0", bus.o_write_reg); end
        checks++; if (bus.o_write_data !== 8'h00) begin errors++; $display("FAIL reset_wd got %h want 00", bus.o_write_data); end
        checks++; if (bus.o_alu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.o_alu_stall); end
        checks++; if (bus.o_ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.o_ld_ready); end
        advance();
    endtask

    task automatic test_alu();
        drive(1, 3, 8'hA5, 0, 0, 0, 3, 0);
        checks++; if (bus.o_pending1 !== 1'b0) begin errors++; $display("FAIL alu_pend_n got %b want 0", bus.o_pending1); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 3, 0);
        checks++; if (bus.o_write_en !== 1'b1) begin errors++; $display("FAIL alu_we got %b want 1", bus.o_write_en); end
        checks++; if (bus.o_write_reg !== 4'd3) begin errors++; $display("FAIL alu_wr got %h want 3", bus.o_write_reg); end
        checks++; if (bus.o_write_data !== 8'hA5) begin errors++; $display("FAIL alu_wd got %h want a5", bus.o_write_data); end
        checks++; if (bus.o_pending1 !== 1'b1) begin errors++; $display("FAIL alu_pend_w got %b want 1", bus.o_pending1); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 3, 0);
        checks++; if (bus.o_write_en !== 1'b0) begin errors++; $display("FAIL alu_we_off got %b want 0", bus.o_write_en); end
        checks++; if (bus.o_pending1 !== 1'b0) begin errors++; $display("FAIL alu_pend_off got %b want 0", bus.o_pending1); end
        advance();
    endtask

    task automatic test_bypass();
        drive(0, 0, 0, 1, 5, 8'h11, 5, 0);
        checks++; if (bus.o_ld_ready !== 1'b1) begin errors++; $display("FAIL byp_ready got %b want 1", bus.o_ld_ready); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 5, 0);
        checks++; if (bus.o_write_en !== 1'b1) begin errors++; $display("FAIL byp_we got %b want 1", bus.o_write_en); end
        checks++; if (bus.o_write_reg !== 4'd5) begin errors++; $display("FAIL byp_wr got %h want 5", bus.o_write_reg); end
        checks++; if (bus.o_write_data !== 8'h11) begin errors++; $display("FAIL byp_wd got %h want 11", bus.o_write_data); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 5, 0);
        checks++; if (bus.o_pending1 !== 1'b0) begin errors++; $display("FAIL byp_not_buffered got %b want 0", bus.o_pending1); end
        checks++; if (bus.o_write_en !== 1'b0) begin errors++; $display("FAIL byp_we_off got %b want 0", bus.o_write_en); end
        advance();
    endtask

    task automatic test_alu_and_load();
        drive(1, 2, 8'h22, 1, 4, 8'h44, 4, 2);
        checks++; if (bus.o_pending1 !== 1'b0) begin errors++; $display("FAIL al_p4_n got %b want 0", bus.o_pending1); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 4, 2);
        checks++; if (bus.o_write_reg !== 4'd2 || bus.o_write_en !== 1'b1) begin errors++; $display("FAIL al_w2 got en=%b reg=%h want en=1 reg=2", bus.o_write_en, bus.o_write_reg); end
        checks++; if (bus.o_write_data !== 8'h22) begin errors++; $display("FAIL al_d2 got %h want 22", bus.o_write_data); end
        checks++; if (bus.o_pending1 !== 1'b1) begin errors++; $display("FAIL al_p4_n1 got %b want 1", bus.o_pending1); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 4, 2);
        checks++; if (bus.o_write_reg !== 4'd4 || bus.o_write_en !== 1'b1) begin errors++; $display("FAIL al_w4 got en=%b reg=%h want en=1 reg=4", bus.o_write_en, bus.o_write_reg); end
        checks++; if (bus.o_write_data !== 8'h44) begin errors++; $display("FAIL al_d4 got %h want 44", bus.o_write_data); end
        checks++; if (bus.o_pending1 !== 1'b1 || bus.o_pending2 !== 1'b0) begin errors++; $display("FAIL al_p_n2 got p4=%b p2=%b want p4=1 p2=0", bus.o_pending1, bus.o_pending2); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 4, 2);
        checks++; if (bus.o_pending1 !== 1'b0) begin errors++; $display("FAIL al_p4_n3 got %b want 0", bus.o_pending1); end
        advance();
    endtask

    task automatic test_starve();
        logic [3:0] dests [3] = '{4'd6, 4'd7, 4'd8};
        logic [3:0] got [$];
        logic [7:0] gotd [$];
        int lo = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1, 1, 8'(k), lo < 3, dests[lo < 3 ? lo : 2], 8'h60 + 8'(lo), 6, 8);
            if (k == 1) begin checks++; if (bus.o_pending1 !== 1'b1) begin errors++; $display("FAIL st_p6 got %b want 1", bus.o_pending1); end end
            if (k == 2) begin checks++; if (bus.o_ld_ready !== 1'b0) begin errors++; $display("FAIL st_full got %b want 0", bus.o_ld_ready); end end
            checks++; if (bus.o_alu_stall !== (k == 5)) begin errors++; $display("FAIL st_stall_k%0d got %b want %b", k, bus.o_alu_stall, k == 5); end
            if (lo < 3 && bus.o_ld_ready) lo++;
            advance();
        end
        for (int j = 0; j < 8; j++) begin
            drive(0, 0, 0, lo < 3, dests[lo < 3 ? lo : 2], 8'h60 + 8'(lo), 6, 8);
            if (j == 0) begin checks++; if (bus.o_ld_ready !== 1'b0 || bus.o_alu_stall !== 1'b0) begin errors++; $display("FAIL st_j0 got ready=%b stall=%b want 0 0", bus.o_ld_ready, bus.o_alu_stall); end end
            if (j == 1) begin checks++; if (bus.o_ld_ready !== 1'b1) begin errors++; $display("FAIL st_ready_back got %b want 1", bus.o_ld_ready); end end
            if (bus.o_write_en && bus.o_write_reg >= 4'd6 && bus.o_write_reg <= 4'd8) begin
                got.push_back(bus.o_write_reg); gotd.push_back(bus.o_write_data);
            end
            if (lo < 3 && bus.o_ld_ready) lo++;
            advance();
        end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL st_count got %0d want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++; if (got[i] !== 4'(6 + i) || gotd[i] !== 8'(8'h60 + i)) begin errors++; $display("FAIL st_order%0d got %h/%h want %h/%h", i, got[i], gotd[i], 6 + i, 8'h60 + i); end
        end
    endtask

    task automatic test_reg_zero();
        drive(1, 0, 8'hFF, 1, 0, 8'hEE, 0, 0);
        checks++; if (bus.o_ld_ready !== 1'b1 || bus.o_pending1 !== 1'b0) begin errors++; $display("FAIL z_accept got ready=%b p0=%b want 1 0", bus.o_ld_ready, bus.o_pending1); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.o_write_en !== 1'b0) begin errors++; $display("FAIL z_we got %b want 0", bus.o_write_en); end
        checks++; if (bus.o_pending1 !== 1'b0 || bus.o_ld_ready !== 1'b1) begin errors++; $display("FAIL z_state got p0=%b ready=%b want 0 1", bus.o_pending1, bus.o_ld_ready); end
        advance();
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 8'h01, 1, 9, 8'h99, 9, 10); advance();
        drive(1, 1, 8'h02, 1, 10, 8'hAA, 9, 10); advance();
        rst = 1;
        drive(1, 1, 8'h03, 0, 0, 0, 9, 10);
        checks++; if (bus.o_ld_ready !== 1'b0 || bus.o_pending1 !== 1'b1 || bus.o_pending2 !== 1'b1) begin errors++; $display("FAIL rm_full got ready=%b p9=%b p10=%b want 0 1 1", bus.o_ld_ready, bus.o_pending1, bus.o_pending2); end
        advance();
        rst = 0;
        drive(0, 0, 0, 0, 0, 0, 9, 10);
        checks++; if (bus.o_write_en !== 1'b0 || bus.o_ld_ready !== 1'b1) begin errors++; $display("FAIL rm_after got we=%b ready=%b want 0 1", bus.o_write_en, bus.o_ld_ready); end
        checks++; if (bus.o_pending1 !== 1'b0 || bus.o_pending2 !== 1'b0) begin errors++; $display("FAIL rm_pend got %b %b want 0 0", bus.o_pending1, bus.o_pending2); end
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 9, 10);
            checks++; if (bus.o_write_en !== 1'b0) begin errors++; $display("FAIL rm_dropped%0d got %b want 0", i, bus.o_write_en); end
            advance();
        end
    endtask

    task automatic test_random();
        logic last_stall = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst = $urandom_range(0, 99) == 0;
            drive(!last_stall && $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 8'($urandom),
                  $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), 8'($urandom),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            checks++; if (bus.o_ld_ready !== e_ready) begin errors++; $display("FAIL rnd_ready@%0d got %b want %b", n, bus.o_ld_ready, e_ready); end
            checks++; if (bus.o_write_en !== m_we) begin errors++; $display("FAIL rnd_we@%0d got %b want %b", n, bus.o_write_en, m_we); end
            checks++; if (bus.o_alu_stall !== m_stall) begin errors++; $display("FAIL rnd_stall@%0d got %b want %b", n, bus.o_alu_stall, m_stall); end
            checks++; if (bus.o_pending1 !== e_p1 || bus.o_pending2 !== e_p2) begin errors++; $display("FAIL rnd_pend@%0d got %b%b want %b%b", n, bus.o_pending1, bus.o_pending2, e_p1, e_p2); end
            if (m_we) begin
                checks++; if (bus.o_write_reg !== m_wr || bus.o_write_data !== m_wd) begin errors++; $display("FAIL rnd_write@%0d got %h/%h want %h/%h", n, bus.o_write_reg, bus.o_write_data, m_wr, m_wd); end
            end
            last_stall = bus.o_alu_stall;
            advance();
        end
        rst = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_bypass();
        test_alu_and_load();
        test_starve();
        test_reg_zero();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
